jtkicker_sndlatch: RTL
======================

Name: jtkicker_sndlatch

Overview:
- Sound-side receiver for main-CPU sound commands: the responder end of the m2s_data / m2s_irq link that main drives.
- Captures command bytes into a small FIFO and generates the sound Z80 interrupt from m2s_irq.
- Releases the interrupt on Z80 acknowledge and presents the head byte on sound-CPU reads.
- Sits inside the sound subsystem, between main-CPU decode and the sound Z80 bus, in the clk24 domain.

Parameters:
- DEPTH, 4: FIFO entries; power of two, 1..8. DEPTH=1 reproduces the original single latch.
- GUARD, 8: cen ticks to hold snd_irqn high after an ack before a queued interrupt re-asserts.

Ports:
- rst  in  1  reset; asynchronous, active-high.
- clk  in  1  clock; clk24, the single clock.
- cen  in  1  sound CPU clock enable (snd_cen).
- main_dout  in  8  main CPU data bus.
- m2s_data  in  1  main write strobe, level. A rising edge writes one byte.
- m2s_irq  in  1  main interrupt request, level. A rising edge requests an IRQ.
- snd_rd  in  1  sound CPU latch-read select, level. A falling edge pops the FIFO.
- irq_ack  in  1  Z80 interrupt acknowledge (M1 & IORQ decoded), level, sampled on cen.
- snd_dout  out  8  latch value seen by the sound CPU.
- snd_irqn  out  1  Z80 INT_n.
- level  out  4  current FIFO occupancy.
- overrun  out  1  sticky; set when a write hits a full FIFO.
- debug_view  out  8  {state[1:0], irq_pend, overrun, level}.

Behaviour:
- Reset values: snd_dout=0, snd_irqn=1, level=0, overrun=0, FSM=IDLE, irq_pend=0, guard counter=0, FIFO pointers=0.
- Edge detection: m2s_data, m2s_irq and snd_rd are registered every clk, not gated by cen. Edges are compared against the registered copy.
- Write:
  - m2s_data rises at cycle N; the byte is written at the end of N+1 and level increments.
  - If the FIFO was empty, snd_dout shows the byte at N+2.
  - main_dout is sampled at N+1; main holds its data at least 2 clk after the strobe rises.
- Full FIFO write: overwrites the newest entry, level unchanged, overrun set. overrun clears only on rst.
- Pop: snd_rd falls (end of the read cycle) at N; at N+1 the read pointer advances and level decrements. snd_dout updates to the new head at N+2.
- Empty pop: ignored. snd_dout keeps the last value, so repeated reads return the same byte as the original latch did.
- Same-cycle push and pop:
  - Non-empty FIFO: both happen, level unchanged.
  - Empty FIFO: push only.
  - Full FIFO: pop, then push; no overrun.
- Wrap: pointers are log2(DEPTH) bits and wrap naturally. level is derived separately and saturates at DEPTH.
- IRQ FSM, all transitions on clk:
  - IDLE: m2s_irq rising edge -> ASSERT, snd_irqn=0.
  - ASSERT: irq_ack && cen -> GUARD, snd_irqn=1, counter loaded with GUARD. An m2s_irq edge while in ASSERT sets irq_pend; further edges do nothing more (one pending max).
  - GUARD: counter decrements on cen. At 0: if irq_pend, clear it and go to ASSERT; else go to IDLE. An m2s_irq edge while in GUARD sets irq_pend.
  - A simultaneous m2s_irq edge and ack in ASSERT: go to GUARD with irq_pend=1.
- IRQ independence: the interrupt path does not depend on FIFO state; a command write never raises the IRQ by itself.
- Reset mid-operation forces all reset values immediately. FIFO contents are don't-care after reset.

Decomposition:
- Shared header (jtkicker_sndlatch.vh): FSM encodings IDLE=2'd0, ASSERT=2'd1, GUARD=2'd2, plus the default DEPTH/GUARD.
- Sub-module jtkicker_cmdfifo: storage, pointers, level, and overwrite-on-full.
- The top holds edge detectors, the IRQ FSM and the debug mux.

Test Plan:
- Single command: reset; write 0x5A -> snd_dout=0x5A at N+2, level=1. Pop -> level=0, snd_dout stays 0x5A.
- Burst, DEPTH=4: write 0x11,0x22,0x33,0x44,0x55 -> overrun=1, level=4. Pops read 0x11,0x22,0x33,0x55. A fifth pop leaves snd_dout=0x55.
- IRQ handshake: m2s_irq edge -> snd_irqn=0 next clk. irq_ack with cen -> snd_irqn=1, and it stays high for 8 cen ticks with no further request.
- Queued IRQ: second m2s_irq edge while in ASSERT, then ack -> snd_irqn high for exactly GUARD=8 cen, then low again. A third edge in GUARD re-asserts exactly once more.
- Simultaneous push/pop at level=2 -> level stays 2 and FIFO order is preserved. Same at level=0 -> level=1.
- Async reset asserted mid-ASSERT with level=3 -> snd_irqn=1, level=0, overrun=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/jtkicker_sndlatch_pkg.sv
// jtkicker_sndlatch_pkg
//   Shared definitions for the sound command latch: IRQ FSM encodings,
//   default sizing and a pointer-width helper used by the FIFO.
package jtkicker_sndlatch_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE   = 2'd0,
    IRQ_ASSERT = 2'd1,
    IRQ_GUARD  = 2'd2
  } irq_state_t;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_GUARD = 8;
  localparam int LEVEL_W   = 4;   // occupancy width, holds 0..8
  localparam int GUARD_W   = 8;   // guard counter width

  // A one-entry FIFO still needs a 1-bit pointer to keep vectors legal;
  // the pointer increment helper keeps it pinned at zero in that case.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/jtkicker_cmdfifo.sv
// jtkicker_cmdfifo
//   Small command FIFO between the main CPU and the sound CPU.
//   A write into a full FIFO overwrites the newest entry and sets the
//   sticky overrun flag. The head byte is held in a register so the sound
//   CPU keeps reading the last byte once the FIFO drains.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   push, pop : one-cycle operation requests (may coincide)
//   din       : byte to push
//   dout      : current head byte (last popped byte when empty)
//   level     : occupancy, saturates at DEPTH
//   overrun   : sticky, set on a push into a full FIFO without a pop
module jtkicker_cmdfifo
  import jtkicker_sndlatch_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [7:0]         din,
  output logic [7:0]         dout,
  output logic [LEVEL_W-1:0] level,
  output logic               overrun
);

  localparam int AW = ptr_width(DEPTH);
  localparam logic [AW-1:0]      LAST_PTR = AW'(DEPTH - 1);
  localparam logic [LEVEL_W-1:0] FULL_LVL = LEVEL_W'(DEPTH);

  logic [7:0] mem [DEPTH];

  logic [AW-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [LEVEL_W-1:0] level_reg, level_next;
  logic [7:0]         dout_reg;
  logic               overrun_reg;

  logic          empty, full, do_pop, overwrite;
  logic [AW-1:0] wr_addr;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [AW-1:0] ptr_dec(input logic [AW-1:0] p);
    return (p == '0) ? LAST_PTR : p - 1'b1;
  endfunction

  always_comb begin
    empty     = (level_reg == '0);
    full      = (level_reg == FULL_LVL);
    do_pop    = pop & ~empty;
    // A push into a full FIFO with no pop frees no slot, so it replaces
    // the newest entry instead of advancing the write pointer.
    overwrite = push & full & ~pop;
    wr_addr   = overwrite ? ptr_dec(wr_ptr_reg) : wr_ptr_reg;

    rd_ptr_next = do_pop ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    wr_ptr_next = (push && !overwrite) ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;

    level_next = level_reg;
    if (push && !full && !do_pop) begin
      level_next = level_reg + 1'b1;
    end else if (do_pop && !push) begin
      level_next = level_reg - 1'b1;
    end
  end

  // Storage: plain array, written without reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_addr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      level_reg   <= '0;
      dout_reg    <= 8'h00;
      overrun_reg <= 1'b0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      level_reg  <= level_next;
      if (overwrite) begin
        overrun_reg <= 1'b1;
      end
      // Registered head read. When the byte being written this cycle is
      // the new head it is not in the array yet, so bypass it. An empty
      // result keeps the previous byte visible.
      if (level_next != '0) begin
        if (push && (wr_addr == rd_ptr_next)) begin
          dout_reg <= din;
        end else begin
          dout_reg <= mem[rd_ptr_next];
        end
      end
    end
  end

  assign dout    = dout_reg;
  assign level   = level_reg;
  assign overrun = overrun_reg;

endmodule

// File: rtl/jtkicker_sndlatch.sv
// jtkicker_sndlatch
//   Sound-side receiver for main CPU commands. Detects edges on the main
//   write strobe, the main IRQ request and the sound read select, feeds a
//   command FIFO, and drives the sound Z80 INT_n with a guard interval
//   after each acknowledge so a queued request is seen as a fresh edge.
// Ports:
//   rst, clk   : asynchronous active-high reset, clk24
//   cen        : sound CPU clock enable
//   main_dout  : main CPU data bus
//   m2s_data   : main write strobe (rising edge writes)
//   m2s_irq    : main IRQ request (rising edge requests)
//   snd_rd     : sound read select (falling edge pops)
//   irq_ack    : Z80 interrupt acknowledge, sampled with cen
//   snd_dout   : byte presented to the sound CPU
//   snd_irqn   : Z80 INT_n
//   level      : FIFO occupancy
//   overrun    : sticky write-into-full flag
//   debug_view : {state, irq_pend, overrun, level}
module jtkicker_sndlatch
  import jtkicker_sndlatch_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int GUARD = DEF_GUARD
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       cen,
  input  logic [7:0] main_dout,
  input  logic       m2s_data,
  input  logic       m2s_irq,
  input  logic       snd_rd,
  input  logic       irq_ack,
  output logic [7:0] snd_dout,
  output logic       snd_irqn,
  output logic [3:0] level,
  output logic       overrun,
  output logic [7:0] debug_view
);

  // Edge detectors run every clk, independent of cen.
  logic data_reg, irq_reg, rd_reg;
  logic data_rise, irq_rise, rd_fall;
  logic push_reg, pop_reg;

  assign data_rise = m2s_data & ~data_reg;
  assign irq_rise  = m2s_irq & ~irq_reg;
  assign rd_fall   = ~snd_rd & rd_reg;

  // Push and pop are delayed one cycle so main_dout is sampled one clk
  // after the strobe edge, and both requests reach the FIFO aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg <= 1'b0;
      irq_reg  <= 1'b0;
      rd_reg   <= 1'b0;
      push_reg <= 1'b0;
      pop_reg  <= 1'b0;
    end else begin
      data_reg <= m2s_data;
      irq_reg  <= m2s_irq;
      rd_reg   <= snd_rd;
      push_reg <= data_rise;
      pop_reg  <= rd_fall;
    end
  end

  jtkicker_cmdfifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_reg),
    .pop     (pop_reg),
    .din     (main_dout),
    .dout    (snd_dout),
    .level   (level),
    .overrun (overrun)
  );

  // IRQ FSM. Independent of the FIFO: a command write never raises INT_n.
  irq_state_t         state_reg;
  logic               snd_irqn_reg;
  logic               irq_pend_reg;
  logic [GUARD_W-1:0] guard_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IRQ_IDLE;
      snd_irqn_reg  <= 1'b1;
      irq_pend_reg  <= 1'b0;
      guard_cnt_reg <= '0;
    end else begin
      unique case (state_reg)
        IRQ_IDLE: begin
          if (irq_rise) begin
            state_reg    <= IRQ_ASSERT;
            snd_irqn_reg <= 1'b0;
          end
        end
        IRQ_ASSERT: begin
          // Only one request is remembered while INT_n is low.
          if (irq_rise) begin
            irq_pend_reg <= 1'b1;
          end
          if (irq_ack && cen) begin
            state_reg     <= IRQ_GUARD;
            snd_irqn_reg  <= 1'b1;
            guard_cnt_reg <= GUARD_W'(GUARD);
          end
        end
        IRQ_GUARD: begin
          if (guard_cnt_reg == '0) begin
            // An edge landing on the expiry cycle counts as pending too.
            if (irq_pend_reg || irq_rise) begin
              irq_pend_reg <= 1'b0;
              state_reg    <= IRQ_ASSERT;
              snd_irqn_reg <= 1'b0;
            end else begin
              state_reg <= IRQ_IDLE;
            end
          end else begin
            if (cen) begin
              guard_cnt_reg <= guard_cnt_reg - 1'b1;
            end
            if (irq_rise) begin
              irq_pend_reg <= 1'b1;
            end
          end
        end
        default: begin
          state_reg    <= IRQ_IDLE;
          snd_irqn_reg <= 1'b1;
          irq_pend_reg <= 1'b0;
        end
      endcase
    end
  end

  assign snd_irqn   = snd_irqn_reg;
  assign debug_view = {state_reg, irq_pend_reg, overrun, level};

endmodule
